// File: rtl/mod_sram_arb_pkg.sv
// Shared types for the SRAM port arbiter: FSM states and owner ids.
package plp_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam logic [1:0] ARB_NONE = 2'd0;
  localparam logic [1:0] ARB_I    = 2'd1;
  localparam logic [1:0] ARB_D    = 2'd2;
  localparam logic [1:0] ARB_V    = 2'd3;

endpackage

// File: rtl/mod_sram_arb_prio.sv
// Combinational winner pick: V > D > I, with V demoted once its run limit is hit
// while a CPU requester is waiting.
module arb_prio
  import plp_arb_pkg::*;
#(
  parameter int VGA_MAX_RUN = 4,
  parameter int RUN_W       = 3
) (
  input  logic             i_elig,
  input  logic             d_elig,
  input  logic             v_elig,
  input  logic [RUN_W-1:0] run,
  output logic [1:0]       owner
);

  logic cpu_waiting;
  logic v_allowed;

  assign cpu_waiting = i_elig | d_elig;
  assign v_allowed   = (run < RUN_W'(VGA_MAX_RUN)) | ~cpu_waiting;

  always_comb begin
    owner = ARB_NONE;
    if (v_elig && v_allowed) owner = ARB_V;
    else if (d_elig)         owner = ARB_D;
    else if (i_elig)         owner = ARB_I;
  end

endmodule

// File: rtl/mod_sram_arb.sv
// Single SRAM port shared by CPU fetch (I), CPU data (D) and VGA reader (V).
// One transaction at a time; the winner's rdy pulses in the first IDLE cycle.
module mod_sram_arb
  import plp_arb_pkg::*;
#(
  parameter int VGA_MAX_RUN = 4,
  parameter int AW          = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [31:0]   i_data,
  output logic          i_rdy,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic [31:0]   d_rdata,
  output logic          d_rdy,
  input  logic          v_req,
  input  logic [AW-1:0] v_addr,
  output logic [31:0]   v_data,
  output logic          v_rdy,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  input  logic [31:0]   m_rdata,
  input  logic          m_done,
  output logic          cpu_stall,
  output logic [1:0]    grant
);

  localparam int RUN_W = $clog2(VGA_MAX_RUN + 1);

  arb_state_t       state, next_state;
  logic [1:0]       owner;
  logic [1:0]       pick;
  logic [RUN_W-1:0] run;

  // A port whose rdy is high is still presenting its finished request.
  logic i_elig, d_elig, v_elig;
  assign i_elig = i_req & ~i_rdy;
  assign d_elig = d_req & ~d_rdy;
  assign v_elig = v_req & ~v_rdy;

  arb_prio #(
    .VGA_MAX_RUN(VGA_MAX_RUN),
    .RUN_W      (RUN_W)
  ) u_prio (
    .i_elig(i_elig),
    .d_elig(d_elig),
    .v_elig(v_elig),
    .run   (run),
    .owner (pick)
  );

  assign cpu_stall = (i_req & ~i_rdy) | (d_req & ~d_rdy);
  assign grant     = (state == ARB_BUSY) ? owner : ARB_NONE;

  always_ff @(posedge clk) begin
    if (!rst) state <= ARB_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ARB_IDLE: if (pick != ARB_NONE) next_state = ARB_BUSY;
      ARB_BUSY: if (m_done)           next_state = ARB_IDLE;
      default:                        next_state = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner   <= ARB_NONE;
      run     <= '0;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_data  <= '0;
      d_rdata <= '0;
      v_data  <= '0;
      i_rdy   <= 1'b0;
      d_rdy   <= 1'b0;
      v_rdy   <= 1'b0;
    end else begin
      i_rdy <= 1'b0;
      d_rdy <= 1'b0;
      v_rdy <= 1'b0;
      if (state == ARB_IDLE && pick != ARB_NONE) begin
        owner   <= pick;
        m_req   <= 1'b1;
        m_we    <= (pick == ARB_D) ? d_we : 1'b0;
        m_wdata <= (pick == ARB_D) ? d_wdata : 32'd0;
        unique case (pick)
          ARB_I:   m_addr <= i_addr;
          ARB_D:   m_addr <= d_addr;
          default: m_addr <= v_addr;
        endcase
        if (pick == ARB_V) begin
          if (run != RUN_W'(VGA_MAX_RUN)) run <= run + 1'b1;
        end else begin
          run <= '0;
        end
      end else if (state == ARB_BUSY && m_done) begin
        m_req <= 1'b0;
        unique case (owner)
          ARB_I: begin
            i_data <= m_rdata;
            i_rdy  <= 1'b1;
          end
          ARB_D: begin
            // Writes complete without disturbing the last read value.
            if (!m_we) d_rdata <= m_rdata;
            d_rdy <= 1'b1;
          end
          ARB_V: begin
            v_data <= m_rdata;
            v_rdy  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mod_sram_arb.sv
// Directed bench for mod_sram_arb: table of single transactions plus hand-written
// sequences for priority order, VGA run limit and mid-transaction reset.
module tb_mod_sram_arb;
  import plp_arb_pkg::*;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_req = 1'b0, d_req = 1'b0, v_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0, v_addr = '0;
  logic [31:0]   d_wdata = '0, m_rdata = '0;
  logic          m_done = 1'b0;
  logic [31:0]   i_data, d_rdata, v_data, m_wdata;
  logic          i_rdy, d_rdy, v_rdy, m_req, m_we, cpu_stall;
  logic [AW-1:0] m_addr;
  logic [1:0]    grant;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_i = '0, exp_d = '0, exp_v = '0;

  typedef struct {
    logic [1:0]  port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gap;
  } vec_t;

  vec_t vecs[6];

  mod_sram_arb #(.VGA_MAX_RUN(4), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_data(i_data), .i_rdy(i_rdy),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_rdy(d_rdy),
    .v_req(v_req), .v_addr(v_addr), .v_data(v_data), .v_rdy(v_rdy),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_done(m_done),
    .cpu_stall(cpu_stall), .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] port, input logic val);
    case (port)
      ARB_I:   i_req = val;
      ARB_D:   d_req = val;
      default: v_req = val;
    endcase
  endtask

  // Called one step after the edge that should have granted `port`.
  task automatic expect_grant(input logic [1:0] port, input logic [31:0] addr,
                              input logic we, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int gap, input logic drop);
    chk("m_req_on_grant", {31'd0, m_req}, 32'd1);
    chk("grant_id", {30'd0, grant}, {30'd0, port});
    chk("m_addr", m_addr, addr);
    chk("m_we", {31'd0, m_we}, {31'd0, we});
    if (we) chk("m_wdata", m_wdata, wdata);
    chk("stall_busy", {31'd0, cpu_stall}, {31'd0, i_req | d_req});
    repeat (gap) begin
      tick();
      chk("m_req_hold", {31'd0, m_req}, 32'd1);
      chk("m_addr_hold", m_addr, addr);
      chk("grant_hold", {30'd0, grant}, {30'd0, port});
      if (we) chk("m_wdata_hold", m_wdata, wdata);
    end
    m_done  = 1'b1;
    m_rdata = rdata;
    tick();
    m_done  = 1'b0;
    if (!we) begin
      case (port)
        ARB_I:   exp_i = rdata;
        ARB_D:   exp_d = rdata;
        default: exp_v = rdata;
      endcase
    end
    chk("i_rdy_pulse", {31'd0, i_rdy}, {31'd0, port == ARB_I});
    chk("d_rdy_pulse", {31'd0, d_rdy}, {31'd0, port == ARB_D});
    chk("v_rdy_pulse", {31'd0, v_rdy}, {31'd0, port == ARB_V});
    chk("i_data", i_data, exp_i);
    chk("d_rdata", d_rdata, exp_d);
    chk("v_data", v_data, exp_v);
    chk("m_req_drop", {31'd0, m_req}, 32'd0);
    chk("grant_idle", {30'd0, grant}, 30'd0);
    chk("stall_rdy", {31'd0, cpu_stall},
        {31'd0, (i_req & (port != ARB_I)) | (d_req & (port != ARB_D))});
    if (drop) set_req(port, 1'b0);
  endtask

  initial begin
    vecs[0] = '{port: ARB_I, we: 1'b0, addr: 32'h100, wdata: 32'h0,        rdata: 32'hDEADBEEF, gap: 1};
    vecs[1] = '{port: ARB_D, we: 1'b1, addr: 32'h20,  wdata: 32'h12345678, rdata: 32'hBAD0BAD0, gap: 1};
    vecs[2] = '{port: ARB_D, we: 1'b0, addr: 32'h24,  wdata: 32'h0,        rdata: 32'hCAFEF00D, gap: 2};
    vecs[3] = '{port: ARB_V, we: 1'b0, addr: 32'h8000, wdata: 32'h0,       rdata: 32'h11112222, gap: 1};
    vecs[4] = '{port: ARB_I, we: 1'b0, addr: 32'h104, wdata: 32'h0,        rdata: 32'h0BADF00D, gap: 10};
    vecs[5] = '{port: ARB_D, we: 1'b1, addr: 32'h28,  wdata: 32'hA5A55A5A, rdata: 32'h77777777, gap: 3};

    // Reset state
    repeat (3) tick();
    chk("rst_m_req", {31'd0, m_req}, 32'd0);
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_rdy", {29'd0, i_rdy, d_rdy, v_rdy}, 32'd0);
    chk("rst_i_data", i_data, 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    rst = 1'b1;
    tick();

    // Single transactions from the table
    for (int n = 0; n < 6; n++) begin
      i_addr  = vecs[n].addr;
      d_addr  = vecs[n].addr;
      v_addr  = vecs[n].addr;
      d_we    = vecs[n].we;
      d_wdata = vecs[n].wdata;
      set_req(vecs[n].port, 1'b1);
      #1;
      chk("stall_cycle0", {31'd0, cpu_stall}, {31'd0, vecs[n].port != ARB_V});
      chk("idle_before_grant", {31'd0, m_req}, 32'd0);
      tick();
      expect_grant(vecs[n].port, vecs[n].addr, vecs[n].we, vecs[n].wdata,
                   vecs[n].rdata, vecs[n].gap, 1'b1);
      tick();
      chk("rdy_one_cycle", {29'd0, i_rdy, d_rdy, v_rdy}, 32'd0);
      chk("idle_after", {31'd0, m_req}, 32'd0);
    end
    d_we = 1'b0;

    // Simultaneous requests: V, then D, then I
    i_addr = 32'h300; d_addr = 32'h304; v_addr = 32'h308;
    i_req = 1'b1; d_req = 1'b1; v_req = 1'b1;
    tick();
    expect_grant(ARB_V, 32'h308, 1'b0, 32'h0, 32'hAAAA0003, 1, 1'b1);
    tick();
    expect_grant(ARB_D, 32'h304, 1'b0, 32'h0, 32'hAAAA0002, 1, 1'b1);
    tick();
    expect_grant(ARB_I, 32'h300, 1'b0, 32'h0, 32'hAAAA0001, 1, 1'b1);
    tick();
    chk("prio_done_rdy", {29'd0, i_rdy, d_rdy, v_rdy}, 32'd0);
    chk("prio_done_idle", {31'd0, m_req}, 32'd0);

    // VGA run limit: four V grants saturate the run, then a waiting D wins
    v_addr = 32'h9000; d_addr = 32'h30;
    v_req = 1'b1;
    tick();
    for (int n = 0; n < 4; n++) begin
      expect_grant(ARB_V, 32'h9000, 1'b0, 32'h0, 32'h5000 + n, 1, 1'b0);
      tick();
      chk("v_rdy_cycle_no_regrant", {31'd0, m_req}, 32'd0);
      if (n == 3) d_req = 1'b1;
      tick();
    end
    expect_grant(ARB_D, 32'h30, 1'b0, 32'h0, 32'h0D0D0D0D, 1, 1'b1);
    tick();
    expect_grant(ARB_V, 32'h9000, 1'b0, 32'h0, 32'h5004, 1, 1'b0);
    tick();
    d_req = 1'b1;
    tick();
    // Run is 1 after the counter cleared, so V still beats D here
    expect_grant(ARB_V, 32'h9000, 1'b0, 32'h0, 32'h5005, 1, 1'b0);
    tick();
    expect_grant(ARB_D, 32'h30, 1'b0, 32'h0, 32'h0E0E0E0E, 1, 1'b1);
    v_req = 1'b0;
    tick();
    chk("run_seq_idle", {31'd0, m_req}, 32'd0);

    // Reset while BUSY abandons the access; stray m_done afterwards is ignored
    i_addr = 32'h200;
    i_req  = 1'b1;
    tick();
    chk("pre_rst_busy", {31'd0, m_req}, 32'd1);
    tick();
    rst = 1'b0;
    tick();
    exp_i = '0; exp_d = '0; exp_v = '0;
    chk("rst_busy_m_req", {31'd0, m_req}, 32'd0);
    chk("rst_busy_grant", {30'd0, grant}, 32'd0);
    chk("rst_busy_rdy", {29'd0, i_rdy, d_rdy, v_rdy}, 32'd0);
    chk("rst_busy_i_data", i_data, exp_i);
    chk("rst_busy_d_rdata", d_rdata, exp_d);
    rst     = 1'b1;
    i_req   = 1'b0;
    m_done  = 1'b1;
    m_rdata = 32'hFFFFFFFF;
    tick();
    m_done = 1'b0;
    chk("stray_done_rdy", {29'd0, i_rdy, d_rdy, v_rdy}, 32'd0);
    chk("stray_done_m_req", {31'd0, m_req}, 32'd0);
    tick();
    chk("stray_done_i_data", i_data, exp_i);
    chk("stray_done_grant", {30'd0, grant}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
